// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: boot, sequential advance, fetch
// handshake, redirect/trap entry, halt/resume and an accepted-fetch counter.
module pc_gen #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_1C00,
  parameter int unsigned STEP     = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  input  logic             pc_ready_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             trap_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic [1:0]       state_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  epc_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic handshake;
  logic target_misaligned;

  assign handshake         = (state_q == S_RUN) && pc_ready_i;
  assign target_misaligned = |redirect_pc_i[1:0];

  // Redirect handling shared by RUN and HALTED; trap has already been ruled out.
  function automatic void apply_redirect(
    input  logic [XLEN-1:0] tgt,
    input  logic            bad,
    output logic [XLEN-1:0] pc_n,
    output logic [XLEN-1:0] epc_n,
    output logic            mis_n,
    input  logic [XLEN-1:0] pc_cur,
    input  logic [XLEN-1:0] epc_cur
  );
    pc_n  = bad ? TRAP_PC[XLEN-1:0] : tgt;
    epc_n = bad ? tgt : epc_cur;
    mis_n = bad;
    if (pc_cur == pc_cur) begin
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_BOOT: state_d = S_RUN;

      S_RUN: begin
        if (trap_i) begin
          pc_d  = TRAP_PC[XLEN-1:0];
          epc_d = pc_q;
        end else if (redirect_i) begin
          apply_redirect(redirect_pc_i, target_misaligned, pc_d, epc_d, misalign_d, pc_q, epc_q);
        end else if (handshake) begin
          pc_d = pc_q + XLEN'(STEP);
        end
        // Accepted fetches count even when the PC is overridden this cycle.
        if (handshake) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (halt_i)    state_d = S_HALT;
      end

      S_HALT: begin
        if (trap_i) begin
          pc_d    = TRAP_PC[XLEN-1:0];
          epc_d   = pc_q;
          state_d = S_RUN;
        end else if (redirect_i) begin
          apply_redirect(redirect_pc_i, target_misaligned, pc_d, epc_d, misalign_d, pc_q, epc_q);
        end
        if (resume_i) state_d = S_RUN;
      end

      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC[XLEN-1:0];
      epc_q      <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = (state_q == S_RUN);
  assign state_o     = state_q;
  assign misalign_o  = misalign_q;
  assign epc_o       = epc_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, backpressure, redirects, trap, halt/resume,
// PC and counter wrap, and reset overriding activity. Counter is 4 bits wide.
module tb_pc_gen;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  pc_o;
  logic             pc_valid_o;
  logic             pc_ready_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             trap_i;
  logic             halt_i;
  logic             resume_i;
  logic [1:0]       state_o;
  logic             misalign_o;
  logic [XLEN-1:0]  epc_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  int checks = 0;
  int errors = 0;

  pc_gen #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_ready_i(pc_ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .trap_i(trap_i), .halt_i(halt_i), .resume_i(resume_i),
    .state_o(state_o), .misalign_o(misalign_o), .epc_o(epc_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [1:0] st,
                         input logic vld, input logic [31:0] epc, input logic mis,
                         input logic [3:0] cnt);
    chk({tag, ".pc"},    pc_o,        pc);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".valid"}, 32'(pc_valid_o), 32'(vld));
    chk({tag, ".epc"},   epc_o,       epc);
    chk({tag, ".mis"},   32'(misalign_o), 32'(mis));
    chk({tag, ".cnt"},   32'(fetch_cnt_o), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; pc_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    trap_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
    step(); step();
    chk_all("reset", 32'h3000, 2'b00, 1'b0, 32'h0, 1'b0, 4'd0);

    // Boot cycle ignores inputs, then RUN with the reset PC.
    rst = 1'b0; pc_ready_i = 1'b1; trap_i = 1'b1;
    step();
    chk_all("boot", 32'h3000, 2'b01, 1'b1, 32'h0, 1'b0, 4'd0);
    trap_i = 1'b0;
    step();
    chk_all("seq1", 32'h3004, 2'b01, 1'b1, 32'h0, 1'b0, 4'd1);
    step();
    chk_all("seq2", 32'h3008, 2'b01, 1'b1, 32'h0, 1'b0, 4'd2);

    // Backpressure with aligned redirect.
    pc_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h4000;
    step();
    chk_all("redir", 32'h4000, 2'b01, 1'b1, 32'h0, 1'b0, 4'd2);

    // Misaligned redirect.
    redirect_pc_i = 32'h4002;
    step();
    chk_all("misal", 32'h1C00, 2'b01, 1'b1, 32'h4002, 1'b1, 4'd2);
    redirect_i = 1'b0; pc_ready_i = 1'b1;
    step();
    chk_all("misal_end", 32'h1C04, 2'b01, 1'b1, 32'h4002, 1'b0, 4'd3);

    // Trap beats redirect; the handshake still counts.
    trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h4000;
    step();
    chk_all("trap", 32'h1C00, 2'b01, 1'b1, 32'h1C04, 1'b0, 4'd4);

    trap_i = 1'b0; pc_ready_i = 1'b0; redirect_pc_i = 32'h3010;
    step();
    chk("to3010.pc", pc_o, 32'h3010);

    // Halt with a handshake in the same cycle.
    redirect_i = 1'b0; halt_i = 1'b1; pc_ready_i = 1'b1;
    step();
    chk_all("halt", 32'h3014, 2'b10, 1'b0, 32'h1C04, 1'b0, 4'd5);

    halt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h5000;
    step();
    chk_all("halt_redir", 32'h5000, 2'b10, 1'b0, 32'h1C04, 1'b0, 4'd5);
    redirect_i = 1'b0;
    step();
    chk_all("halt_hold", 32'h5000, 2'b10, 1'b0, 32'h1C04, 1'b0, 4'd5);

    // Misaligned redirect while halted stays halted.
    redirect_i = 1'b1; redirect_pc_i = 32'h5001;
    step();
    chk_all("halt_misal", 32'h1C00, 2'b10, 1'b0, 32'h5001, 1'b1, 4'd5);
    redirect_pc_i = 32'h5000;
    step();
    chk_all("halt_back", 32'h5000, 2'b10, 1'b0, 32'h5001, 1'b0, 4'd5);

    // Resume wins over halt.
    redirect_i = 1'b0; halt_i = 1'b1; resume_i = 1'b1; pc_ready_i = 1'b0;
    step();
    chk_all("resume", 32'h5000, 2'b01, 1'b1, 32'h5001, 1'b0, 4'd5);

    // PC wrap.
    halt_i = 1'b0; resume_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre.pc", pc_o, 32'hFFFF_FFFC);
    redirect_i = 1'b0; pc_ready_i = 1'b1;
    step();
    chk_all("pc_wrap", 32'h0, 2'b01, 1'b1, 32'h5001, 1'b0, 4'd6);

    // Counter wrap: 9 more handshakes reach 15, one more wraps to 0.
    for (int i = 0; i < 9; i++) step();
    chk_all("cnt15", 32'h24, 2'b01, 1'b1, 32'h5001, 1'b0, 4'd15);
    step();
    chk_all("cnt_wrap", 32'h28, 2'b01, 1'b1, 32'h5001, 1'b0, 4'd0);

    // Trap while halted returns to RUN.
    halt_i = 1'b1; pc_ready_i = 1'b0;
    step();
    chk_all("halt2", 32'h28, 2'b10, 1'b0, 32'h5001, 1'b0, 4'd0);
    halt_i = 1'b0; trap_i = 1'b1;
    step();
    chk_all("halt_trap", 32'h1C00, 2'b01, 1'b1, 32'h28, 1'b0, 4'd0);

    // Reset overrides trap and handshake.
    trap_i = 1'b1; pc_ready_i = 1'b1; rst = 1'b1;
    step();
    chk_all("rst_mid", 32'h3000, 2'b00, 1'b0, 32'h0, 1'b0, 4'd0);
    rst = 1'b0; trap_i = 1'b0; pc_ready_i = 1'b0;
    step();
    chk_all("reboot", 32'h3000, 2'b01, 1'b1, 32'h0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
